// File: rtl/regbank_wb_sched.sv
// Register-bank writeback arbiter (ALU vs MEM, round-robin) with pending-write scoreboard.
// Optional same-cycle bypass of the registered write enabled by REGBANK_WB_FWD_EN.
module regbank_wb_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_req,
  input  logic [3:0]  alu_addr,
  input  logic [15:0] alu_data,
  output logic        alu_gnt,
  input  logic        mem_req,
  input  logic [3:0]  mem_addr,
  input  logic [15:0] mem_data,
  output logic        mem_gnt,
  output logic        wr_en,
  output logic [3:0]  wr_addr,
  output logic [15:0] wr_data,
  input  logic        issue_en,
  input  logic [3:0]  issue_addr,
  output logic        issue_full,
  input  logic [3:0]  rd_addr_a,
  input  logic [3:0]  rd_addr_b,
  output logic        haz_a,
  output logic        haz_b,
  output logic        fwd_a_vld,
  output logic [15:0] fwd_a_data,
  output logic        fwd_b_vld,
  output logic [15:0] fwd_b_data
);

  typedef enum logic {
    WIN_ALU = 1'b0,
    WIN_MEM = 1'b1
  } win_e;

  win_e        last_q, last_d;
  logic        wr_en_q, wr_en_d;
  logic [3:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic [1:0]  cnt_q [16];
  logic [1:0]  cnt_d [16];
  logic [15:0] inc_v, dec_v;
  logic        pick_alu, pick_mem;
  logic [1:0]  cnt_rd_a, cnt_rd_b;

  // pick terms are mutually exclusive by construction
  assign pick_alu = alu_req && (!mem_req || last_q == WIN_MEM);
  assign pick_mem = mem_req && (!alu_req || last_q == WIN_ALU);

  always_comb begin
    alu_gnt   = 1'b0;
    mem_gnt   = 1'b0;
    last_d    = last_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (rst_n) begin
      unique case (1'b1)
        pick_alu: begin
          alu_gnt   = 1'b1;
          last_d    = WIN_ALU;
          wr_en_d   = 1'b1;
          wr_addr_d = alu_addr;
          wr_data_d = alu_data;
        end
        pick_mem: begin
          mem_gnt   = 1'b1;
          last_d    = WIN_MEM;
          wr_en_d   = 1'b1;
          wr_addr_d = mem_addr;
          wr_data_d = mem_data;
        end
        default: ;
      endcase
    end
  end

  // saturating counters; simultaneous inc and dec cancel out
  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int i = 0; i < 16; i++) begin
      cnt_d[i] = cnt_q[i];
      inc_v[i] = issue_en && (issue_addr == 4'(i))
                 && (cnt_q[i] != 2'd3);
      dec_v[i] = wr_en_q && (wr_addr_q == 4'(i))
                 && (cnt_q[i] != 2'd0);
      if (inc_v[i] && !dec_v[i]) begin
        cnt_d[i] = cnt_q[i] + 2'd1;
      end else if (dec_v[i] && !inc_v[i]) begin
        cnt_d[i] = cnt_q[i] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q    <= WIN_MEM;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < 16; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      last_q    <= last_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      for (int i = 0; i < 16; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign issue_full = (cnt_q[issue_addr] == 2'd3);
  assign cnt_rd_a   = cnt_q[rd_addr_a];
  assign cnt_rd_b   = cnt_q[rd_addr_b];

`ifdef REGBANK_WB_FWD_EN
  logic match_a, match_b;

  assign match_a    = wr_en_q && (wr_addr_q == rd_addr_a);
  assign match_b    = wr_en_q && (wr_addr_q == rd_addr_b);
  assign fwd_a_vld  = match_a;
  assign fwd_b_vld  = match_b;
  assign fwd_a_data = match_a ? wr_data_q : '0;
  assign fwd_b_data = match_b ? wr_data_q : '0;
  // last outstanding write is the one being bypassed
  assign haz_a = (cnt_rd_a != 2'd0)
                 && !(match_a && cnt_rd_a == 2'd1);
  assign haz_b = (cnt_rd_b != 2'd0)
                 && !(match_b && cnt_rd_b == 2'd1);
`else
  assign fwd_a_vld  = 1'b0;
  assign fwd_b_vld  = 1'b0;
  assign fwd_a_data = '0;
  assign fwd_b_data = '0;
  assign haz_a      = (cnt_rd_a != 2'd0);
  assign haz_b      = (cnt_rd_b != 2'd0);
`endif

endmodule

// File: tb/tb_regbank_wb_sched.sv
// Bench for regbank_wb_sched: arbitration vector table, write scoreboard,
// and hand sequences for counters, bypass and mid-run reset.
module tb_regbank_wb_sched;

`ifdef REGBANK_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_req, mem_req;
  logic [3:0]  alu_addr, mem_addr;
  logic [15:0] alu_data, mem_data;
  logic        alu_gnt, mem_gnt;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        issue_en;
  logic [3:0]  issue_addr;
  logic        issue_full;
  logic [3:0]  rd_addr_a, rd_addr_b;
  logic        haz_a, haz_b;
  logic        fwd_a_vld, fwd_b_vld;
  logic [15:0] fwd_a_data, fwd_b_data;

  regbank_wb_sched dut (
    .clk(clk), .rst_n(rst_n),
    .alu_req(alu_req), .alu_addr(alu_addr),
    .alu_data(alu_data), .alu_gnt(alu_gnt),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_gnt(mem_gnt),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .issue_full(issue_full),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .haz_a(haz_a), .haz_b(haz_b),
    .fwd_a_vld(fwd_a_vld), .fwd_a_data(fwd_a_data),
    .fwd_b_vld(fwd_b_vld), .fwd_b_data(fwd_b_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ar;
    logic [3:0]  aa;
    logic [15:0] ad;
    logic        mr;
    logic [3:0]  ma;
    logic [15:0] md;
    logic        ega;
    logic        egm;
  } vec_t;

  typedef struct packed {
    logic        en;
    logic [3:0]  a;
    logic [15:0] d;
  } wr_t;

  vec_t        tbl [15];
  wr_t         sb_q [$];
  logic [3:0]  exp_wa;
  logic [15:0] exp_wd;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // grant check, scoreboard push, then pop against the registered write
  task automatic tick(input logic ega, input logic egm);
    wr_t e;
    #1;
    chk("alu_gnt", 16'(alu_gnt), 16'(ega));
    chk("mem_gnt", 16'(mem_gnt), 16'(egm));
    if (ega) begin
      exp_wa = alu_addr;
      exp_wd = alu_data;
    end else if (egm) begin
      exp_wa = mem_addr;
      exp_wd = mem_data;
    end
    sb_q.push_back('{ega | egm, exp_wa, exp_wd});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 16'd1, 16'd0);
    end else begin
      e = sb_q.pop_front();
      chk("wr_en", 16'(wr_en), 16'(e.en));
      chk("wr_addr", 16'(wr_addr), 16'(e.a));
      chk("wr_data", wr_data, e.d);
    end
  endtask

  initial begin
    tbl[0]  = '{1'b1, 4'd3, 16'h1234, 1'b1, 4'd5, 16'hBEEF, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 4'd3, 16'h1234, 1'b1, 4'd5, 16'hBEEF, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 4'd1, 16'h0101, 1'b1, 4'd6, 16'h0606, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 4'd1, 16'h0101, 1'b1, 4'd6, 16'h0606, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 4'd2, 16'h0202, 1'b1, 4'd8, 16'h0808, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 4'd2, 16'h0202, 1'b1, 4'd8, 16'h0808, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 4'd4, 16'h4444, 1'b0, 4'd9, 16'h9999, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 4'd10, 16'hAAAA, 1'b0, 4'd9, 16'h9999, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 4'd11, 16'hBBBB, 1'b0, 4'd9, 16'h9999, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 4'd11, 16'hBBBB, 1'b1, 4'd12, 16'hCCCC, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 4'd9, 16'h0A09, 1'b1, 4'd9, 16'h0B09, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 4'd9, 16'h0A09, 1'b1, 4'd9, 16'h0B09, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 4'd15, 16'hFFFF, 1'b1, 4'd14, 16'hEEEE, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 4'd15, 16'hFFFF, 1'b0, 4'd14, 16'hEEEE, 1'b0, 1'b0};

    rst_n = 1'b0;
    alu_req = 1'b1; alu_addr = 4'd3; alu_data = 16'h1234;
    mem_req = 1'b1; mem_addr = 4'd5; mem_data = 16'hBEEF;
    issue_en = 1'b0; issue_addr = 4'd0;
    rd_addr_a = 4'd0; rd_addr_b = 4'd0;
    exp_wa = 4'd0; exp_wd = 16'd0;
    #1;
    chk("rst_alu_gnt", 16'(alu_gnt), 16'd0);
    chk("rst_mem_gnt", 16'(mem_gnt), 16'd0);
    chk("rst_wr_en", 16'(wr_en), 16'd0);
    chk("rst_wr_addr", 16'(wr_addr), 16'd0);
    chk("rst_wr_data", wr_data, 16'd0);
    chk("rst_haz_a", 16'(haz_a), 16'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      alu_req = tbl[i].ar; alu_addr = tbl[i].aa;
      alu_data = tbl[i].ad;
      mem_req = tbl[i].mr; mem_addr = tbl[i].ma;
      mem_data = tbl[i].md;
      tick(tbl[i].ega, tbl[i].egm);
    end

    // issue saturation on r7, then drain with three writes
    issue_en = 1'b1; issue_addr = 4'd7; rd_addr_a = 4'd7;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("issue_full", 16'(issue_full), 16'(k == 3));
      tick(1'b0, 1'b0);
    end
    issue_en = 1'b0;
    chk("haz_a_sat", 16'(haz_a), 16'd1);
    alu_req = 1'b1; alu_addr = 4'd7; alu_data = 16'h0707;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    chk("haz_a_cnt2", 16'(haz_a), 16'd1);
    tick(1'b1, 1'b0);
    alu_req = 1'b0;
    #1;
    chk("haz_a_last", 16'(haz_a), 16'(!FWD));
    chk("fwd_a_vld", 16'(fwd_a_vld), 16'(FWD));
    chk("fwd_a_data", fwd_a_data, FWD ? 16'h0707 : 16'h0000);
    tick(1'b0, 1'b0);
    chk("haz_a_drain", 16'(haz_a), 16'd0);

    // issue and writeback on r2 in the same cycle
    issue_en = 1'b1; issue_addr = 4'd2; rd_addr_b = 4'd2;
    tick(1'b0, 1'b0);
    issue_en = 1'b0;
    alu_req = 1'b1; alu_addr = 4'd2; alu_data = 16'h2222;
    tick(1'b1, 1'b0);
    alu_req = 1'b0;
    issue_en = 1'b1;
    tick(1'b0, 1'b0);
    issue_en = 1'b0;
    chk("haz_b_incdec", 16'(haz_b), 16'd1);
    mem_req = 1'b1; mem_addr = 4'd2; mem_data = 16'h2323;
    tick(1'b0, 1'b1);
    mem_req = 1'b0;
    tick(1'b0, 1'b0);
    chk("haz_b_r2_clr", 16'(haz_b), 16'd0);

    // bypass on r4; r9 held pending for the reset check
    issue_en = 1'b1; issue_addr = 4'd9; rd_addr_a = 4'd9;
    tick(1'b0, 1'b0);
    issue_addr = 4'd4; rd_addr_b = 4'd4;
    tick(1'b0, 1'b0);
    issue_en = 1'b0;
    alu_req = 1'b1; alu_addr = 4'd4; alu_data = 16'hA5A5;
    tick(1'b1, 1'b0);
    alu_req = 1'b0;
    #1;
    chk("fwd_b_vld", 16'(fwd_b_vld), 16'(FWD));
    chk("fwd_b_data", fwd_b_data, FWD ? 16'hA5A5 : 16'h0000);
    chk("haz_b_fwd", 16'(haz_b), 16'(!FWD));
    chk("haz_a_r9", 16'(haz_a), 16'd1);

    // asynchronous reset with a write in flight
    alu_req = 1'b1; alu_addr = 4'd3; alu_data = 16'h1111;
    mem_req = 1'b1; mem_addr = 4'd5; mem_data = 16'h2222;
    rst_n = 1'b0;
    #1;
    chk("arst_wr_en", 16'(wr_en), 16'd0);
    chk("arst_wr_addr", 16'(wr_addr), 16'd0);
    chk("arst_wr_data", wr_data, 16'd0);
    chk("arst_alu_gnt", 16'(alu_gnt), 16'd0);
    chk("arst_mem_gnt", 16'(mem_gnt), 16'd0);
    sb_q.delete();
    exp_wa = 4'd0; exp_wd = 16'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_haz_a", 16'(haz_a), 16'd0);
    chk("post_haz_b", 16'(haz_b), 16'd0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    alu_req = 1'b0; mem_req = 1'b0;
    tick(1'b0, 1'b0);
    chk("sb_drained", 16'(sb_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/regbank_wb_sched.md
REGBANK_WB_SCHED -- requirements
Module: regbank_wb_sched

Interface
REQ-001 The block SHALL expose the following ports, one per line: name, direction, width, meaning (clock and reset first):
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- alu_req  in  1  ALU writeback request; held until granted
- alu_addr  in  4  ALU destination register
- alu_data  in  16  ALU result
- alu_gnt  out  1  combinational; ALU request accepted this cycle
- mem_req  in  1  load writeback request; held until granted
- mem_addr  in  4  load destination register
- mem_data  in  16  load data
- mem_gnt  out  1  combinational; load request accepted this cycle
- wr_en  out  1  registered; register-bank write enable
- wr_addr  out  4  registered; register-bank write address
- wr_data  out  16  registered; register-bank write data
- issue_en  in  1  instruction issued with a destination register
- issue_addr  in  4  issued destination register
- issue_full  out  1  combinational; pending count of issue_addr is 3
- rd_addr_a  in  4  read port A address
- rd_addr_b  in  4  read port B address
- haz_a  out  1  combinational; read A has an outstanding write
- haz_b  out  1  combinational; read B has an outstanding write
- fwd_a_vld  out  1  read A is bypassed this cycle
- fwd_a_data  out  16  bypass data for A
- fwd_b_vld  out  1  read B is bypassed this cycle
- fwd_b_data  out  16  bypass data for B
REQ-002 The block SHALL have no parameters; the data width is fixed at 16 and the register count at 16.

Function
REQ-003 Arbitration SHALL be round-robin between ALU and MEM, tracked in a 1-bit last-winner register.
REQ-004 With one requester active, that requester SHALL be granted the same cycle.
REQ-005 With both active, the requester that is not the last winner SHALL be granted; last-winner updates at the edge.
REQ-006 At most one gnt SHALL be high per cycle; with no request, both gnt SHALL be 0 and last-winner SHALL hold.
REQ-007 On a grant, the granted addr/data SHALL be registered into wr_addr/wr_data and wr_en set to 1 at the next edge (latency 1 cycle); with no grant, wr_en SHALL be 0 next cycle and wr_addr/wr_data SHALL hold.
REQ-008 Both requesters targeting the same address SHALL be serialized in arbitration order; no merge or drop.
REQ-009 The scoreboard SHALL keep a 2-bit pending count per register (16 counters).
REQ-010 issue_en with count<3 SHALL increment count[issue_addr].
REQ-011 issue_en with count==3 SHALL be ignored, with issue_full asserted in that cycle.
REQ-012 When wr_en=1, count[wr_addr] SHALL decrement; a decrement at 0 SHALL stay 0 (no wrap).
REQ-013 An increment and a decrement on the same register in one cycle SHALL leave the count unchanged.
REQ-014 haz_x SHALL be (count[rd_addr_x]!=0), subject to REQ-019.

Reset
REQ-015 While rst_n=0, the block SHALL force wr_en=0, wr_addr=0, wr_data=0, all counts=0, and last-winner=MEM, so ALU wins the first tie.
REQ-016 Reset assertion mid-operation SHALL discard any registered write immediately (wr_en drops asynchronously) and clear all pending counts.
REQ-017 Grants SHALL be 0 while rst_n=0.

Configuration
REQ-018 Macro REGBANK_WB_FWD_EN SHALL enable same-cycle bypass.
REQ-019 With REGBANK_WB_FWD_EN defined:
- fwd_x_vld=1 when wr_en=1 and wr_addr==rd_addr_x; then fwd_x_data=wr_data.
- haz_x SHALL be 0 when that match holds and count[rd_addr_x]==1.
REQ-020 Without REGBANK_WB_FWD_EN:
- fwd_a_vld, fwd_b_vld, fwd_a_data and fwd_b_data SHALL be constant 0.
- haz_x SHALL follow REQ-014 unmodified.

Verification
REQ-021 alu_req=1 (addr 3, data 0x1234) and mem_req=1 (addr 5, data 0xBEEF) in the first cycle after reset -> alu_gnt=1; next cycle wr_en=1, wr_addr=3, wr_data=0x1234; next cycle mem_gnt=1; following cycle wr_addr=5, wr_data=0xBEEF.
REQ-022 Both requests held continuously for 6 cycles -> grants alternate ALU, MEM, ALU, MEM, ALU, MEM.
REQ-023 issue_en to register 7 four times -> count reaches 3; fourth cycle issue_full=1 and count stays 3; three writes to register 7 -> haz_a with rd_addr_a=7 drops to 0 after the third write.
REQ-024 issue_en addr 2 in the same cycle as wr_en=1, wr_addr=2 with count 1 -> count stays 1 and haz remains 1.
REQ-025 With REGBANK_WB_FWD_EN, count[4]=1, wr_en=1, wr_addr=4, wr_data=0xA5A5, rd_addr_b=4 -> fwd_b_vld=1, fwd_b_data=0xA5A5, haz_b=0; without the macro -> fwd_b_vld=0, haz_b=1.
REQ-026 rst_n pulled low while wr_en=1 and counts are nonzero -> wr_en=0 immediately and all haz outputs 0 after release.
